seven_seg_scan_driver: RTL and testbench
========================================

Name: seven_seg_scan_driver

Overview:
Parametrised, time-multiplexed hex display driver for a common-anode multi-digit seven-segment bank, decoding a packed DIGITS×4-bit value.
Adds per-digit scanning with an anti-ghost guard band, frame-synchronous tear-free update via a load/pending handshake, leading-zero blanking and per-digit decimal points.
Sits between the datapath result registers and the board's segment/anode pins.

Parameters:
DIGITS, 4, number of digits scanned (1..8).
REFRESH_DIV, 50000, clk cycles per digit slot (must be >= GUARD+2).
GUARD, 2, cycles at the start of each slot with all anodes off.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
enable  in  1  1 = scan active; 0 = display dark, scan held at start.
load  in  1  single-cycle strobe that captures value/dp_in into the shadow register.
value  in  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 is the rightmost digit.
dp_in  in  DIGITS  decimal point request per digit, 1 = on.
blank_lz  in  1  1 = suppress leading zeros.
seg  out  7  active-low segments {A,B,C,D,E,F,G}; A is the MSB.
dp_n  out  1  active-low decimal point.
an  out  DIGITS  active-low anode enables; at most one bit is low at any time.
pending  out  1  shadow loaded but not yet displayed.
frame_done  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (async assert):
  - seg=7'b1111111, dp_n=1, an all 1, pending=0, frame_done=0.
  - Slot counter cnt=0, digit index idx=0, shadow=0, display register disp=0.
- Scan:
  - cnt counts 0..REFRESH_DIV-1 and wraps.
  - At cnt==REFRESH_DIV-1, idx advances by 1; after DIGITS-1 it wraps to 0.
- Outputs are registered with 1-cycle latency from (cnt, idx, disp):
  - If cnt<GUARD: an all 1, seg=7'b1111111, dp_n=1.
  - Otherwise: an[idx]=0, seg=decode(disp nibble idx), dp_n=~dp bit idx.
  - Hence an[idx] goes low in the cycle after cnt==GUARD, and rises in the cycle after cnt returns to 0.
- Decode table (hex 0..F, active-low ABCDEFG):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Leading-zero blanking (blank_lz=1):
  - Digit i is blanked (seg=1111111) if every nibble from DIGITS-1 down to i is 0.
  - Digit 0 is never blanked.
  - A blanked digit still drives its anode and its dp.
  - blank_lz is sampled live, not shadowed.
- Load handshake:
  - load=1: shadow <= {value, dp_in}; pending <= 1.
  - Back-to-back loads overwrite shadow; only the last one is displayed.
- Frame boundary:
  - Occurs at the cycle with cnt==REFRESH_DIV-1 and idx==DIGITS-1.
  - On that cycle: disp <= shadow, pending <= 0, and frame_done pulses 1 on the next cycle.
  - If load coincides with the boundary, the new value bypasses into disp and pending stays 0.
- enable=0:
  - cnt, idx held at 0; an all 1, seg all 1, dp_n=1; no frame_done pulses.
  - disp tracks shadow every cycle; pending=0 (a load sets pending for that cycle only, then the copy clears it).
  - load is still accepted.
  - Re-enable starts at slot 0, guard first.
- Reset mid-frame: everything returns to the reset state immediately; no partial digit is left lit.
- Width rules:
  - cnt width is $clog2(REFRESH_DIV); idx width is $clog2(DIGITS), minimum 1.
  - No arithmetic overflow is possible beyond these wraps.

Test Plan:
1. Reset release, DIGITS=4, REFRESH_DIV=8, GUARD=2, enable=1:
   - an low sequence 1110, 1101, 1011, 0111 per 8-cycle slot, each preceded by 2 cycles of an=1111.
   - seg=0000001 throughout.
   - frame_done pulses every 32 cycles.
2. load value=16'h12AF, dp_in=4'b0010 mid-frame:
   - pending=1 until the boundary; old digits still shown until then.
   - Next frame: digit0 seg=0111000, digit1 0001000 with dp_n=0, digit2 0010010, digit3 1001111.
3. blank_lz=1, value=16'h0040:
   - Digits 3 and 2 show seg=1111111 (anode still pulses).
   - Digit 1 shows 1001100; digit 0 shows 0000001.
   - value=0 shows only digit 0 as '0'.
4. load asserted exactly on the boundary cycle:
   - New value displayed in the immediately following frame.
   - pending never rises.
   - frame_done pulses the next cycle.
5. Two loads 3 cycles apart (16'h1111, then 16'h2222):
   - Only 2222 ever appears.
   - pending clears once.
6. reset asserted during a digit-2 lit phase:
   - an=1111 and seg=1111111 on the same edge.
   - After release, scan restarts at digit 0 with the guard band.
   - disp=0.
   - Also enable=0 mid-scan: display goes dark one cycle later.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
//
// Time-multiplexed hex driver for a common-anode seven-segment bank.
// The driver scans one digit per slot of REFRESH_DIV clocks. The first
// GUARD clocks of every slot keep all anodes off so the previous digit's
// segments never ghost onto the next one. New values enter through a
// shadow register. The shadow is copied into the displayed register only
// at a frame boundary, so a frame never shows a mix of old and new digits.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   enable     in   1 = scanning; 0 = dark, scan held at slot 0
//   load       in   strobe: capture value/dp_in into the shadow register
//   value      in   DIGITS hex nibbles, nibble 0 = rightmost digit
//   dp_in      in   decimal point request per digit (1 = on)
//   blank_lz   in   1 = suppress leading zeros (sampled live)
//   seg        out  active-low segments {A,B,C,D,E,F,G}
//   dp_n       out  active-low decimal point
//   an         out  active-low anode enables, at most one low
//   pending    out  shadow holds a value not yet displayed
//   frame_done out  one-cycle pulse after each frame boundary
//
// Handshake: a load in any cycle is always accepted (there is no ready).
// The load sets pending until the next frame boundary consumes the shadow.
// A load in the boundary cycle goes straight to the display, and in that
// case pending never rises.
module seven_seg_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [4*DIGITS-1:0]    shadow_val;
    logic [DIGITS-1:0]      shadow_dp;
    logic [4*DIGITS-1:0]    disp_val;
    logic [DIGITS-1:0]      disp_dp;

    logic                   slot_end;
    logic                   boundary;
    logic [3:0]             cur_nib;
    logic                   cur_dp;
    logic                   upper_zero;
    logic [DIGITS-1:0]      an_lit;
    logic                   blank_cur;

    // Active-low ABCDEFG patterns for hex 0..F.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    assign slot_end = (cnt == CNT_LAST);
    assign boundary = enable && slot_end && (idx == IDX_LAST);

    // Select the current digit's nibble, dp bit and anode pattern. The
    // digit counts as a leading zero when it and every nibble above it
    // are zero.
    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        upper_zero = 1'b0;
        an_lit     = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib    = disp_val[4*i +: 4];
                cur_dp     = disp_dp[i];
                an_lit[i]  = 1'b0;
                upper_zero = ((disp_val >> (4*i)) == '0);
            end
        end
    end

    // Digit 0 always shows, so a zero value still displays "0".
    assign blank_cur = blank_lz && (idx != '0) && upper_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            seg        <= 7'b1111111;
            dp_n       <= 1'b1;
            an         <= '1;
        end else begin
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
            end

            frame_done <= boundary;

            if (!enable) begin
                // While dark the display simply follows the shadow, so
                // pending only lasts for the cycle after a load.
                cnt      <= '0;
                idx      <= '0;
                disp_val <= shadow_val;
                disp_dp  <= shadow_dp;
                pending  <= load;
            end else begin
                if (slot_end) begin
                    cnt <= '0;
                    idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
                end else begin
                    cnt <= cnt + CW'(1);
                end

                if (boundary) begin
                    // A load in the boundary cycle bypasses the shadow.
                    disp_val <= load ? value : shadow_val;
                    disp_dp  <= load ? dp_in : shadow_dp;
                    pending  <= 1'b0;
                end else if (load) begin
                    pending <= 1'b1;
                end
            end

            // Outputs are registered from the pre-edge cnt/idx/disp.
            if (!enable || (cnt < CNT_GUARD)) begin
                an   <= '1;
                seg  <= 7'b1111111;
                dp_n <= 1'b1;
            end else begin
                an   <= an_lit;
                seg  <= blank_cur ? 7'b1111111 : decode(cur_nib);
                dp_n <= ~cur_dp;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Testbench for seven_seg_scan_driver (DIGITS=4, REFRESH_DIV=8, GUARD=2).
// A cycle-time model predicts every output each cycle. Directed scenarios
// add literal expectations at key points.
module tb_seven_seg_scan_driver;

    localparam int DIGITS = 4;
    localparam int RD     = 8;
    localparam int GUARD  = 2;

    logic         clk;
    logic         rst;
    logic         enable;
    logic         load;
    logic [15:0]  value;
    logic [3:0]   dp_in;
    logic         blank_lz;
    logic [6:0]   seg;
    logic         dp_n;
    logic [3:0]   an;
    logic         pending;
    logic         frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    seven_seg_scan_driver #(
        .DIGITS(DIGITS),
        .REFRESH_DIV(RD),
        .GUARD(GUARD)
    ) dut (
        .clk(clk),
        .reset(rst),
        .enable(enable),
        .load(load),
        .value(value),
        .dp_in(dp_in),
        .blank_lz(blank_lz),
        .seg(seg),
        .dp_n(dp_n),
        .an(an),
        .pending(pending),
        .frame_done(frame_done)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    int          t;          // cycles since the scan last started
    logic [15:0] m_shadow_val, m_disp_val;
    logic [3:0]  m_shadow_dp, m_disp_dp;
    logic        m_pending;
    logic [6:0]  exp_seg;
    logic        exp_dp_n;
    logic [3:0]  exp_an;
    logic        exp_pending;
    logic        exp_fd;
    int          slot, dig;
    logic        bnd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t = 0;
            m_shadow_val = '0; m_shadow_dp = '0;
            m_disp_val = '0;   m_disp_dp = '0;
            m_pending = 1'b0;
            exp_seg = 7'h7f; exp_dp_n = 1'b1; exp_an = 4'hf;
            exp_pending = 1'b0; exp_fd = 1'b0;
        end else begin
            slot = t % RD;
            dig  = (t / RD) % DIGITS;
            bnd  = enable && (slot == RD - 1) && (dig == DIGITS - 1);
            if (!enable || slot < GUARD) begin
                exp_an = 4'hf; exp_seg = 7'h7f; exp_dp_n = 1'b1;
            end else begin
                exp_an   = ~(4'b0001 << dig);
                exp_dp_n = ~m_disp_dp[dig];
                if (blank_lz && dig != 0 && (m_disp_val >> (4*dig)) == 16'h0)
                    exp_seg = 7'h7f;
                else
                    exp_seg = seg_tab[(m_disp_val >> (4*dig)) & 16'hf];
            end
            exp_fd = bnd;
            if (!enable) begin
                m_disp_val = m_shadow_val;
                m_disp_dp  = m_shadow_dp;
                m_pending  = load;
                t = 0;
            end else begin
                if (bnd) begin
                    m_disp_val = load ? value : m_shadow_val;
                    m_disp_dp  = load ? dp_in : m_shadow_dp;
                    m_pending  = 1'b0;
                end else if (load) begin
                    m_pending = 1'b1;
                end
                t = t + 1;
            end
            if (load) begin
                m_shadow_val = value;
                m_shadow_dp  = dp_in;
            end
            exp_pending = m_pending;
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst === 1'b0) begin
                check("cyc_seg", seg, exp_seg);
                check("cyc_dp_n", dp_n, exp_dp_n);
                check("cyc_an", an, exp_an);
                check("cyc_pending", pending, exp_pending);
                check("cyc_frame_done", frame_done, exp_fd);
            end
        end
    end

    // ---------------- drivers ----------------
    // All drivers run at negedge.
    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v; dp_in = d; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] pat, input int budget, output int n);
        n = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            n++;
            if (an === pat) return;
        end
        check("wait_an_timeout", {28'h0, an}, {28'h0, pat});
    endtask

    task automatic wait_fd(input int budget, output int n);
        n = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            n++;
            if (frame_done === 1'b1) return;
        end
        check("wait_fd_timeout", frame_done, 1'b1);
    endtask

    task automatic show(input logic [3:0] pat, input logic [6:0] s, input logic d, input string nm);
        int n;
        wait_an(pat, 40, n);
        check({nm, "_seg"}, seg, s);
        check({nm, "_dp_n"}, dp_n, d);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst = 1'b1; enable = 1'b1; load = 1'b0;
        value = '0; dp_in = '0; blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_seg", seg, 7'h7f);
        check("rst_an", an, 4'hf);
        check("rst_dp_n", dp_n, 1'b1);
        check("rst_pending", pending, 1'b0);
        check("rst_fd", frame_done, 1'b0);
        rst = 1'b0;

        // 1: scan of zeros after reset
        wait_an(4'b1110, 10, n);
        check("t1_first_lit_delay", n, GUARD + 1);
        check("t1_d0_seg", seg, 7'b0000001);
        show(4'b1101, 7'b0000001, 1'b1, "t1_d1");
        show(4'b1011, 7'b0000001, 1'b1, "t1_d2");
        show(4'b0111, 7'b0000001, 1'b1, "t1_d3");
        wait_fd(40, n);
        wait_fd(40, n);
        check("t1_frame_period", n, DIGITS * RD);

        // 2: mid-frame load waits for the boundary
        repeat (5) @(negedge clk);
        do_load(16'h12AF, 4'b0010);
        check("t2_pending_set", pending, 1'b1);
        show(4'b1101, 7'b0000001, 1'b1, "t2_old_d1");
        wait_fd(40, n);
        check("t2_pending_clr", pending, 1'b0);
        show(4'b1110, 7'b0111000, 1'b1, "t2_d0");
        show(4'b1101, 7'b0001000, 1'b0, "t2_d1");
        show(4'b1011, 7'b0010010, 1'b1, "t2_d2");
        show(4'b0111, 7'b1001111, 1'b1, "t2_d3");

        // 3: leading-zero blanking
        blank_lz = 1'b1;
        do_load(16'h0040, 4'b0000);
        wait_fd(40, n);
        show(4'b1110, 7'b0000001, 1'b1, "t3_d0");
        show(4'b1101, 7'b1001100, 1'b1, "t3_d1");
        show(4'b1011, 7'b1111111, 1'b1, "t3_d2");
        show(4'b0111, 7'b1111111, 1'b1, "t3_d3");
        do_load(16'h0000, 4'b0000);
        wait_fd(40, n);
        show(4'b1110, 7'b0000001, 1'b1, "t3z_d0");
        show(4'b1101, 7'b1111111, 1'b1, "t3z_d1");
        blank_lz = 1'b0;

        // 4: load exactly on the boundary cycle
        wait_fd(40, n);
        repeat (DIGITS * RD - 1) @(negedge clk);
        do_load(16'h5A3C, 4'b1001);
        check("t4_fd", frame_done, 1'b1);
        check("t4_pending", pending, 1'b0);
        show(4'b1110, 7'b0110001, 1'b0, "t4_d0");
        show(4'b1101, 7'b0000110, 1'b1, "t4_d1");

        // 5: back-to-back loads, only the last shows
        wait_fd(40, n);
        repeat (2) @(negedge clk);
        do_load(16'h1111, 4'b0000);
        repeat (2) @(negedge clk);
        do_load(16'h2222, 4'b0000);
        check("t5_pending", pending, 1'b1);
        wait_fd(40, n);
        show(4'b1110, 7'b0010010, 1'b1, "t5_d0");

        // 6: reset during digit 2, then enable drop
        wait_an(4'b1011, 40, n);
        rst = 1'b1;
        #1;
        check("t6_rst_an", an, 4'hf);
        check("t6_rst_seg", seg, 7'h7f);
        check("t6_rst_pending", pending, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_an(4'b1110, 10, n);
        check("t6_restart_delay", n, GUARD + 1);
        check("t6_disp_zero", seg, 7'b0000001);

        wait_an(4'b1101, 20, n);
        enable = 1'b0;
        @(negedge clk);
        check("t6_dark_an", an, 4'hf);
        check("t6_dark_seg", seg, 7'h7f);
        do_load(16'h0007, 4'b0000);
        check("t6_dis_pending_hi", pending, 1'b1);
        @(negedge clk);
        check("t6_dis_pending_lo", pending, 1'b0);
        enable = 1'b1;
        wait_an(4'b1110, 10, n);
        check("t6_reenable_delay", n, GUARD + 1);
        check("t6_reenable_seg", seg, 7'b0001111);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
